msrv32_fetch_ctrl: RTL and testbench

Sequencing controller for the program-counter register (msrv32_reg_block_1) and the instruction-memory fetch port. It decides each cycle whether the PC register loads, and from which source: boot address, PC+4, branch target, trap vector or MEPC. It also runs the imem request/acknowledge handshake, holds on pipeline stalls, flushes wrong-path fetches and detects fetch timeouts. It sits between the hazard unit, branch unit, CSR/trap logic and the PC register.

---
 rtl/msrv32_fetch_pkg.sv | 22 ++
 rtl/msrv32_redirect_sel.sv | 39 +++
 rtl/msrv32_fetch_ctrl.sv | 179 +++++++++++++++++
 tb/tb_msrv32_fetch_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_fetch_pkg.sv
// Shared types and constants for the fetch/PC sequencing controller.
package msrv32_fetch_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_e;

  // Redirect sources, encoded so that a larger value means higher priority.
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    BRANCH = 2'd1,
    MRET   = 2'd2,
    TRAP   = 2'd3
  } src_e;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/msrv32_redirect_sel.sv
// Priority select (trap > mret > branch) of a redirect source and target,
// with a word-alignment check on branch/mret targets. Trap vectors are
// always forced to word alignment.
module msrv32_redirect_sel
  import msrv32_fetch_pkg::*;
(
  input  logic        trap_taken,
  input  logic [31:0] trap_vec,
  input  logic        mret,
  input  logic [31:0] epc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output src_e        src,
  output logic [31:0] target,
  output logic        misaligned
);

  // Pick the highest-priority active redirect and flag unaligned targets.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    src        = NONE;
    target     = '0;
    misaligned = 1'b0;
    if (trap_taken) begin
      src    = TRAP;
      target = trap_vec & ~32'd3;
    end else if (mret) begin
      src        = MRET;
      target     = epc;
      misaligned = (epc[1:0] != 2'b00);
    end else if (branch_taken) begin
      src        = BRANCH;
      target     = branch_target;
      misaligned = (branch_target[1:0] != 2'b00);
    end
  end

endmodule

// File: rtl/msrv32_fetch_ctrl.sv
// PC-load sequencing and imem request/ack handshake controller. Redirects
// seen while a fetch is outstanding are held in a one-entry pending slot and
// applied (with a flush) when the ack arrives.
module msrv32_fetch_ctrl
  import msrv32_fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter int          MAX_WAIT  = 16
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:0] pc_in,
  input  logic        stall_in,
  input  logic        branch_taken_in,
  input  logic [31:0] branch_target_in,
  input  logic        mret_in,
  input  logic [31:0] epc_in,
  input  logic        trap_taken_in,
  input  logic [31:0] trap_vec_in,
  input  logic        imem_ack_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  output logic [31:0] pc_mux_out,
  output logic        pc_load_out,
  output logic        flush_out,
  output logic        misaligned_out,
  output logic        fetch_fault_out
);

  state_e      state, state_nx;
  src_e        pend_src, pend_src_nx;
  logic [31:0] pend_tgt, pend_tgt_nx;
  logic [7:0]  wait_cnt, wait_nx;

  src_e        live_src;
  logic [31:0] live_tgt;
  logic        live_mis;
  src_e        sel_src;
  logic [31:0] sel_tgt;
  logic        sel_mis;

  // Live redirect inputs on their own: used to decide pending capture.
  msrv32_redirect_sel u_live (
    .trap_taken    (trap_taken_in),
    .trap_vec      (trap_vec_in),
    .mret          (mret_in),
    .epc           (epc_in),
    .branch_taken  (branch_taken_in),
    .branch_target (branch_target_in),
    .src           (live_src),
    .target        (live_tgt),
    .misaligned    (live_mis)
  );

  // Live inputs merged with the pending slot. On equal priority the pending
  // entry keeps its target, so only a strictly higher source replaces it.
  msrv32_redirect_sel u_merge (
    .trap_taken    (trap_taken_in | (pend_src == TRAP)),
    .trap_vec      ((pend_src == TRAP) ? pend_tgt : trap_vec_in),
    .mret          (mret_in | (pend_src == MRET)),
    .epc           ((pend_src == MRET) ? pend_tgt : epc_in),
    .branch_taken  (branch_taken_in | (pend_src == BRANCH)),
    .branch_target ((pend_src == BRANCH) ? pend_tgt : branch_target_in),
    .src           (sel_src),
    .target        (sel_tgt),
    .misaligned    (sel_mis)
  );

  // Next-state and output decode for the fetch sequencer.
  always_comb begin
    state_nx        = state;
    pend_src_nx     = pend_src;
    pend_tgt_nx     = pend_tgt;
    wait_nx         = wait_cnt;
    imem_req_out    = 1'b0;
    imem_addr_out   = '0;
    pc_mux_out      = pc_in;
    pc_load_out     = 1'b0;
    flush_out       = 1'b0;
    misaligned_out  = 1'b0;
    fetch_fault_out = 1'b0;

    unique case (state)
      BOOT: begin
        pc_mux_out  = BOOT_ADDR;
        // Load is suppressed while reset is held so the reset-time outputs
        // stay quiet; the load fires on the first cycle after release.
        pc_load_out = ms_riscv32_mp_rst_in;
        state_nx    = FETCH;
      end

      FETCH: begin
        imem_req_out  = 1'b1;
        imem_addr_out = pc_in;
        if (imem_ack_in) begin
          wait_nx = '0;
          if (sel_mis) begin
            misaligned_out = 1'b1;
          end else if (sel_src != NONE) begin
            pc_mux_out  = sel_tgt;
            pc_load_out = 1'b1;
            flush_out   = 1'b1;
            pend_src_nx = NONE;
            pend_tgt_nx = '0;
          end else if (stall_in) begin
            state_nx = HOLD;
          end else begin
            pc_mux_out  = pc_in + PC_INC;
            pc_load_out = 1'b1;
          end
        end else begin
          wait_nx = wait_cnt + 8'd1;
          if (sel_mis) begin
            misaligned_out = 1'b1;
          end else if (live_src > pend_src) begin
            pend_src_nx = live_src;
            pend_tgt_nx = live_tgt;
          end
          if (wait_cnt == 8'(MAX_WAIT - 1)) begin
            state_nx = FAULT;
          end
        end
      end

      HOLD: begin
        if (sel_mis) begin
          misaligned_out = 1'b1;
        end else if (sel_src != NONE) begin
          pc_mux_out  = sel_tgt;
          pc_load_out = 1'b1;
          flush_out   = 1'b1;
          pend_src_nx = NONE;
          pend_tgt_nx = '0;
          state_nx    = FETCH;
        end else if (!stall_in) begin
          pc_mux_out  = pc_in + PC_INC;
          pc_load_out = 1'b1;
          state_nx    = FETCH;
        end
      end

      FAULT: begin
        fetch_fault_out = 1'b1;
        if (trap_taken_in) begin
          pc_mux_out  = trap_vec_in & ~32'd3;
          pc_load_out = 1'b1;
          flush_out   = 1'b1;
          wait_nx     = '0;
          pend_src_nx = NONE;
          pend_tgt_nx = '0;
          state_nx    = FETCH;
        end
      end

      default: state_nx = BOOT;
    endcase
  end

  // State, pending redirect slot and fetch-wait counter.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state    <= BOOT;
      pend_src <= NONE;
      pend_tgt <= '0;
      wait_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state    <= state_nx;
      pend_src <= pend_src_nx;
      pend_tgt <= pend_tgt_nx;
      wait_cnt <= wait_nx;
    end
  end

  logic unused_live_mis;
  assign unused_live_mis = live_mis;

endmodule

// File: tb/tb_msrv32_fetch_ctrl.sv
// Directed self-checking bench for msrv32_fetch_ctrl. A small PC register
// model closes the pc_mux_out/pc_load_out -> pc_in loop.
module tb_msrv32_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        stall_in, branch_taken_in, mret_in, trap_taken_in, imem_ack_in;
  logic [31:0] branch_target_in, epc_in, trap_vec_in;
  logic        imem_req_out, pc_load_out, flush_out, misaligned_out, fetch_fault_out;
  logic [31:0] imem_addr_out, pc_mux_out;

  logic        pc_set;
  logic [31:0] pc_set_val;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  msrv32_fetch_ctrl #(.BOOT_ADDR(32'h0000_0000), .MAX_WAIT(16)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .pc_in                (pc_in),
    .stall_in             (stall_in),
    .branch_taken_in      (branch_taken_in),
    .branch_target_in     (branch_target_in),
    .mret_in              (mret_in),
    .epc_in               (epc_in),
    .trap_taken_in        (trap_taken_in),
    .trap_vec_in          (trap_vec_in),
    .imem_ack_in          (imem_ack_in),
    .imem_req_out         (imem_req_out),
    .imem_addr_out        (imem_addr_out),
    .pc_mux_out           (pc_mux_out),
    .pc_load_out          (pc_load_out),
    .flush_out            (flush_out),
    .misaligned_out       (misaligned_out),
    .fetch_fault_out      (fetch_fault_out)
  );

  // PC register model; pc_set lets the bench plant an arbitrary PC.
  always @(posedge clk) begin
    if (pc_set)           pc_in <= pc_set_val;
    else if (pc_load_out) pc_in <= pc_mux_out;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus at the falling edge, then let outputs settle.
  task automatic drive(input logic ack, input logic stall,
                       input logic br, input logic [31:0] bt,
                       input logic mr, input logic [31:0] ep,
                       input logic tr, input logic [31:0] tv);
    @(negedge clk);
    pc_set           = 1'b0;
    imem_ack_in      = ack;
    stall_in         = stall;
    branch_taken_in  = br;
    branch_target_in = bt;
    mret_in          = mr;
    epc_in           = ep;
    trap_taken_in    = tr;
    trap_vec_in      = tv;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; pc_set = 1'b0; pc_set_val = '0;
    imem_ack_in = 1'b0; stall_in = 1'b0;
    branch_taken_in = 1'b0; branch_target_in = '0;
    mret_in = 1'b0; epc_in = '0; trap_taken_in = 1'b0; trap_vec_in = '0;
    #2;
    check("rst_load",  32'(pc_load_out),     0);
    check("rst_mux",   pc_mux_out,           32'h0);
    check("rst_req",   32'(imem_req_out),    0);
    check("rst_fault", 32'(fetch_fault_out), 0);

    // Boot then sequential fetch with ack tied high.
    @(negedge clk); rst_n = 1'b1; imem_ack_in = 1'b1; #1;
    check("boot_load",  32'(pc_load_out), 1);
    check("boot_mux",   pc_mux_out,       32'h0);
    check("boot_req",   32'(imem_req_out), 0);
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      check("seq_mux",   pc_mux_out,       32'(4 * i));
      check("seq_load",  32'(pc_load_out), 1);
      check("seq_flush", 32'(flush_out),   0);
    end

    // Branch during an outstanding fetch is held until the ack.
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    pc_set = 1'b1; pc_set_val = 32'h0205_A608;
    drive(0, 0, 1, 32'h0ABC_7654, 0, 0, 0, 0);
    check("br_wait_load", 32'(pc_load_out), 0);
    check("br_wait_addr", imem_addr_out,    32'h0205_A608);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("br_wait2_load", 32'(pc_load_out), 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("br_ack_mux",   pc_mux_out,       32'h0ABC_7654);
    check("br_ack_load",  32'(pc_load_out), 1);
    check("br_ack_flush", 32'(flush_out),   1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("br_after_mux",   pc_mux_out,     32'h0ABC_7658);
    check("br_after_flush", 32'(flush_out), 0);

    // Trap, mret and branch together: trap wins, others dropped.
    drive(0, 0, 1, 32'h3000, 1, 32'h2000, 1, 32'h0000_0103);
    check("prio_wait_load", 32'(pc_load_out), 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("prio_mux",   pc_mux_out,     32'h100);
    check("prio_flush", 32'(flush_out), 1);

    // Stall at ack -> HOLD, then PC+4 on release.
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    check("stall_ack_load", 32'(pc_load_out),  0);
    check("stall_ack_req",  32'(imem_req_out), 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0, 0, 0, 0);
      check("hold_req",  32'(imem_req_out), 0);
      check("hold_load", 32'(pc_load_out),  0);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("unstall_mux",  pc_mux_out,       32'h104);
    check("unstall_load", 32'(pc_load_out), 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("refetch_mux", pc_mux_out, 32'h108);

    // Misaligned branch at ack and misaligned mret while waiting.
    drive(1, 0, 1, 32'h0000_0206, 0, 0, 0, 0);
    check("mis_br_pulse", 32'(misaligned_out), 1);
    check("mis_br_load",  32'(pc_load_out),    0);
    check("mis_br_flush", 32'(flush_out),      0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("mis_br_clear", 32'(misaligned_out), 0);
    check("mis_br_pc",    pc_mux_out,          32'h10C);
    drive(0, 0, 0, 0, 1, 32'h2001, 0, 0);
    check("mis_mret_pulse", 32'(misaligned_out), 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("mis_mret_drop_mux",   pc_mux_out,     32'h110);
    check("mis_mret_drop_flush", 32'(flush_out), 0);

    // Pending upgrade: branch, then higher mret, then lower branch ignored.
    drive(0, 0, 1, 32'h400, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h500, 0, 0);
    drive(0, 0, 1, 32'h600, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("pend_upg_mux",   pc_mux_out,     32'h500);
    check("pend_upg_flush", 32'(flush_out), 1);

    // Fetch timeout after MAX_WAIT cycles without ack.
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      check("to_wait_fault", 32'(fetch_fault_out), 0);
    end
    drive(0, 0, 1, 32'h700, 0, 0, 0, 0);
    check("fault_level", 32'(fetch_fault_out), 1);
    check("fault_req",   32'(imem_req_out),    0);
    check("fault_br_ld", 32'(pc_load_out),     0);
    drive(1, 0, 0, 0, 1, 32'h900, 0, 0);
    check("fault_hold",    32'(fetch_fault_out), 1);
    check("fault_mret_ld", 32'(pc_load_out),     0);
    drive(0, 0, 0, 0, 0, 0, 1, 32'h80);
    check("fault_trap_mux",   pc_mux_out,       32'h80);
    check("fault_trap_load",  32'(pc_load_out), 1);
    check("fault_trap_flush", 32'(flush_out),   1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("fault_exit",      32'(fetch_fault_out), 0);
    check("fault_exit_addr", imem_addr_out,        32'h80);

    // Asynchronous reset in the middle of a wait.
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2; rst_n = 1'b0; imem_ack_in = 1'b1; #1;
    check("arst_req",   32'(imem_req_out),    0);
    check("arst_addr",  imem_addr_out,        32'h0);
    check("arst_load",  32'(pc_load_out),     0);
    check("arst_fault", 32'(fetch_fault_out), 0);
    check("arst_mux",   pc_mux_out,           32'h0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("arst_late_ack", 32'(pc_load_out), 0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("reboot_load", 32'(pc_load_out), 1);
    check("reboot_mux",  pc_mux_out,       32'h0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("reboot_seq", pc_mux_out, 32'h4);

    // PC+4 wraps modulo 2^32.
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    pc_set = 1'b1; pc_set_val = 32'hFFFF_FFFC;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("wrap_mux",  pc_mux_out,       32'h0);
    check("wrap_load", 32'(pc_load_out), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
